// File: rtl/logic_op_arbiter_pkg.sv
// rtl/logic_op_arbiter_pkg.sv - opcode and FSM state types for the shared logic-op arbiter
package logic_op_arbiter_pkg;

  typedef enum logic [2:0] {
    OP_BUF  = 3'd0,
    OP_NOT  = 3'd1,
    OP_AND  = 3'd2,
    OP_NAND = 3'd3,
    OP_OR   = 3'd4,
    OP_NOR  = 3'd5,
    OP_XOR  = 3'd6,
    OP_XNOR = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/logic_op_unit.sv
// rtl/logic_op_unit.sv - combinational bitwise gate datapath shared by all requesters
module logic_op_unit
  import logic_op_arbiter_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  op_e              op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] y_o
);

  always_comb begin
    y_o = a_i;
    case (op_i)
      OP_BUF:  y_o = a_i;
      OP_NOT:  y_o = ~a_i;
      OP_AND:  y_o = a_i & b_i;
      OP_NAND: y_o = ~(a_i & b_i);
      OP_OR:   y_o = a_i | b_i;
      OP_NOR:  y_o = ~(a_i | b_i);
      OP_XOR:  y_o = a_i ^ b_i;
      OP_XNOR: y_o = ~(a_i ^ b_i);
      default: y_o = a_i;
    endcase
  end

endmodule

// File: rtl/logic_op_arbiter.sv
// rtl/logic_op_arbiter.sv - round-robin arbiter in front of one shared logic unit
// Optional per-requester grant counters: LOGIC_OP_ARBITER_STATS_EN
module logic_op_arbiter
  import logic_op_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8,
  parameter int IDW     = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [3*NUM_REQ-1:0]     req_op,
  input  logic [WIDTH*NUM_REQ-1:0] req_a,
  input  logic [WIDTH*NUM_REQ-1:0] req_b,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [WIDTH-1:0]         rsp_data,
  output logic [IDW-1:0]           rsp_id
`ifdef LOGIC_OP_ARBITER_STATS_EN
  ,
  output logic [16*NUM_REQ-1:0]    stat_grants
`endif
);

  state_e           state_q, state_d;
  logic [IDW-1:0]   rr_q, rr_d;
  logic [IDW-1:0]   id_q, id_d;
  op_e              op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic [IDW-1:0]   rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] unit_y;

  op_e              op_arr [NUM_REQ];
  logic [WIDTH-1:0] a_arr  [NUM_REQ];
  logic [WIDTH-1:0] b_arr  [NUM_REQ];

  logic             grant_found;
  logic [IDW-1:0]   grant_idx;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      op_arr[i] = op_e'(req_op[i*3 +: 3]);
      a_arr[i]  = req_a[i*WIDTH +: WIDTH];
      b_arr[i]  = req_b[i*WIDTH +: WIDTH];
    end
  end

  // First valid requester at or after rr_q, wrapping at NUM_REQ.
  always_comb begin
    int idx;
    idx         = 0;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!grant_found && req_valid[IDW'(idx)]) begin
        grant_found = 1'b1;
        grant_idx   = IDW'(idx);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    id_d       = id_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    rsp_data_d = rsp_data_q;
    rsp_id_d   = rsp_id_q;
    req_ready  = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (grant_found) begin
          req_ready = NUM_REQ'(1) << grant_idx;
          op_d      = op_arr[grant_idx];
          a_d       = a_arr[grant_idx];
          b_d       = b_arr[grant_idx];
          id_d      = grant_idx;
          rr_d      = (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + IDW'(1);
          state_d   = ST_EXEC;
        end
      end
      ST_EXEC: begin
        rsp_data_d = unit_y;
        rsp_id_d   = id_q;
        state_d    = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      rr_q       <= '0;
      id_q       <= '0;
      op_q       <= OP_BUF;
      a_q        <= '0;
      b_q        <= '0;
      rsp_data_q <= '0;
      rsp_id_q   <= '0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      id_q       <= id_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      rsp_data_q <= rsp_data_d;
      rsp_id_q   <= rsp_id_d;
    end
  end

  logic_op_unit #(.WIDTH(WIDTH)) u_unit (
    .op_i (op_q),
    .a_i  (a_q),
    .b_i  (b_q),
    .y_o  (unit_y)
  );

  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;

`ifdef LOGIC_OP_ARBITER_STATS_EN
  logic [15:0] grant_cnt_q [NUM_REQ];

  // Saturating so a long-running count never wraps back to a small value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REQ; i++) grant_cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_ready[i] && grant_cnt_q[i] != 16'hFFFF) grant_cnt_q[i] <= grant_cnt_q[i] + 16'd1;
      end
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_stat
    assign stat_grants[g*16 +: 16] = grant_cnt_q[g];
  end
`endif

endmodule
